// File: rtl/ship_hit_if.sv
// ship_hit_if: shot request / hit result handshake between a shooter and ship_hit_tracker
interface ship_hit_if #(parameter int GRID_BITS = 3);
  logic                 shot_valid;
  logic                 shot_ready;
  logic [GRID_BITS-1:0] shot_row;
  logic [GRID_BITS-1:0] shot_col;
  logic                 res_valid;
  logic                 res_ready;
  logic                 res_hit;
  logic                 res_repeat;
  modport master (
    output shot_valid, shot_row, shot_col, res_ready,
    input  shot_ready, res_valid, res_hit, res_repeat
  );
  modport slave (
    input  shot_valid, shot_row, shot_col, res_ready,
    output shot_ready, res_valid, res_hit, res_repeat
  );
endinterface

// File: rtl/ship_hit_tracker.sv
// ship_hit_tracker: tracks shots against one placed ship; SHIP_HIT_TRACKER_SHOT_COUNT_EN adds a saturating shot counter
module ship_hit_tracker #(
  parameter int SHIP_SIZE = 3,
  parameter int GRID_BITS = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 place,
  input  logic [GRID_BITS-1:0] ship_row,
  input  logic [GRID_BITS-1:0] ship_col,
  input  logic                 ship_vert,
  ship_hit_if.slave            bus,
  output logic [SHIP_SIZE-1:0] seg_hit
`ifdef SHIP_HIT_TRACKER_SHOT_COUNT_EN
  ,
  output logic [7:0]           shot_count
`endif
);
  typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;
  state_t               state_q;
  logic [GRID_BITS-1:0] row_q, col_q, srow_q, scol_q;
  logic                 vert_q, hit_q, rep_q;
  logic [SHIP_SIZE-1:0] seg_q, seg_d, seg_mask;
  logic [GRID_BITS-1:0] ship_ax, shot_ax;
  logic [GRID_BITS:0]   k;
  logic                 on_ship, rep_d;
`ifdef SHIP_HIT_TRACKER_SHOT_COUNT_EN
  logic [7:0]           cnt_q;
  assign shot_count = cnt_q;
`endif
  assign bus.shot_ready = (state_q == IDLE) && !place;
  assign bus.res_valid  = (state_q == RESP);
  assign bus.res_hit    = hit_q;
  assign bus.res_repeat = rep_q;
  assign seg_hit        = seg_q;
  // k is one bit wider than a coordinate so a shot left of the bow never aliases onto the ship
  always_comb begin
    ship_ax  = vert_q ? row_q : col_q;
    shot_ax  = vert_q ? srow_q : scol_q;
    k        = {1'b0, shot_ax} - {1'b0, ship_ax};
    on_ship  = (vert_q ? (scol_q == col_q) : (srow_q == row_q)) && (shot_ax >= ship_ax)
               && (k < (GRID_BITS+1)'(SHIP_SIZE));
    seg_mask = on_ship ? (SHIP_SIZE'(1) << k) : '0;
    seg_d    = seg_q | seg_mask;
    rep_d    = |(seg_q & seg_mask);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      vert_q  <= 1'b0;
      srow_q  <= '0;
      scol_q  <= '0;
      seg_q   <= '0;
      hit_q   <= 1'b0;
      rep_q   <= 1'b0;
`ifdef SHIP_HIT_TRACKER_SHOT_COUNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (place) begin
            row_q  <= ship_row;
            col_q  <= ship_col;
            vert_q <= ship_vert;
            seg_q  <= '0;
`ifdef SHIP_HIT_TRACKER_SHOT_COUNT_EN
            cnt_q  <= '0;
`endif
          end else if (bus.shot_valid) begin
            srow_q  <= bus.shot_row;
            scol_q  <= bus.shot_col;
            state_q <= CHECK;
`ifdef SHIP_HIT_TRACKER_SHOT_COUNT_EN
            cnt_q   <= (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
`endif
          end
        end
        CHECK: begin
          seg_q   <= seg_d;
          hit_q   <= on_ship;
          rep_q   <= rep_d;
          state_q <= RESP;
        end
        RESP:    state_q <= bus.res_ready ? IDLE : RESP;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ship_hit_tracker.sv
// tb_ship_hit_tracker: vector table of placements/shots plus directed stall, collision and reset sequences
module tb_ship_hit_tracker;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       place = 1'b0;
  logic [2:0] ship_row = '0, ship_col = '0;
  logic       ship_vert = 1'b0;
  logic [2:0] seg_hit;
  int         total = 0, bad = 0;
  ship_hit_if #(.GRID_BITS(3)) bus ();
`ifdef SHIP_HIT_TRACKER_SHOT_COUNT_EN
  logic [7:0] shot_count;
`endif
  ship_hit_tracker #(.SHIP_SIZE(3), .GRID_BITS(3)) dut (
    .clk(clk), .reset_n(reset_n), .place(place), .ship_row(ship_row), .ship_col(ship_col),
    .ship_vert(ship_vert), .bus(bus), .seg_hit(seg_hit)
`ifdef SHIP_HIT_TRACKER_SHOT_COUNT_EN
    , .shot_count(shot_count)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    bit         pl;
    logic [2:0] r, c;
    bit         v, h, rp;
    logic [2:0] seg;
  } vec_t;
  vec_t vt[19];
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic do_place(input logic [2:0] r, c, input bit v);
    @(negedge clk);
    place = 1'b1; ship_row = r; ship_col = c; ship_vert = v;
    @(negedge clk);
    place = 1'b0;
    chk("place_seg", seg_hit, 0);
    chk("place_res_valid", bus.res_valid, 0);
  endtask
  task automatic do_shot(input logic [2:0] r, c, input bit h, rp, input logic [2:0] seg);
    int lat;
    @(negedge clk);
    chk("shot_ready", bus.shot_ready, 1);
    bus.shot_valid = 1'b1; bus.shot_row = r; bus.shot_col = c;
    @(negedge clk);
    bus.shot_valid = 1'b0;
    lat = 1;
    while (!bus.res_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 2);
    chk("res_hit", bus.res_hit, h);
    chk("res_repeat", bus.res_repeat, rp);
    chk("seg_hit", seg_hit, seg);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("res_valid_drop", bus.res_valid, 0);
  endtask
  initial begin
    bus.shot_valid = 1'b0; bus.shot_row = '0; bus.shot_col = '0; bus.res_ready = 1'b0;
    vt[0]  = '{1, 2, 3, 0, 0, 0, 3'b000};
    vt[1]  = '{0, 2, 4, 0, 1, 0, 3'b010};
    vt[2]  = '{0, 2, 4, 0, 1, 1, 3'b010};
    vt[3]  = '{0, 3, 3, 0, 0, 0, 3'b010};
    vt[4]  = '{0, 2, 2, 0, 0, 0, 3'b010};
    vt[5]  = '{0, 2, 5, 0, 1, 0, 3'b110};
    vt[6]  = '{0, 2, 6, 0, 0, 0, 3'b110};
    vt[7]  = '{0, 2, 3, 0, 1, 0, 3'b111};
    vt[8]  = '{0, 2, 3, 0, 1, 1, 3'b111};
    vt[9]  = '{0, 0, 0, 0, 0, 0, 3'b111};
    vt[10] = '{1, 6, 0, 1, 0, 0, 3'b000};
    vt[11] = '{0, 6, 0, 0, 1, 0, 3'b001};
    vt[12] = '{0, 7, 0, 0, 1, 0, 3'b011};
    vt[13] = '{0, 0, 0, 0, 0, 0, 3'b011};
    vt[14] = '{0, 6, 1, 0, 0, 0, 3'b011};
    vt[15] = '{1, 0, 5, 0, 0, 0, 3'b000};
    vt[16] = '{0, 0, 7, 0, 1, 0, 3'b100};
    vt[17] = '{0, 1, 5, 0, 0, 0, 3'b100};
    vt[18] = '{0, 0, 5, 0, 1, 0, 3'b101};
    #12;
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_seg", seg_hit, 0);
    chk("rst_hit", bus.res_hit, 0);
    chk("rst_repeat", bus.res_repeat, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", bus.shot_ready, 1);
    for (int i = 0; i < 19; i++) begin
      if (vt[i].pl) do_place(vt[i].r, vt[i].c, vt[i].v);
      else do_shot(vt[i].r, vt[i].c, vt[i].h, vt[i].rp, vt[i].seg);
    end
    // stall in RESP: result holds, new shot and new placement both ignored
    do_place(2, 3, 0);
    @(negedge clk);
    bus.shot_valid = 1'b1; bus.shot_row = 3'd2; bus.shot_col = 3'd4;
    @(negedge clk);
    bus.shot_row = 3'd2; bus.shot_col = 3'd3;
    @(negedge clk);
    place = 1'b1; ship_row = 3'd5; ship_col = 3'd5; ship_vert = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", bus.res_valid, 1);
      chk("stall_hit", bus.res_hit, 1);
      chk("stall_repeat", bus.res_repeat, 0);
      chk("stall_ready", bus.shot_ready, 0);
      chk("stall_seg", seg_hit, 3'b010);
    end
    place = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0; bus.shot_valid = 1'b0;
    chk("stall_release", bus.res_valid, 0);
    repeat (3) @(negedge clk);
    chk("stall_no_shot", bus.res_valid, 0);
    do_shot(2, 4, 1, 1, 3'b010);
    // place and shot in the same cycle: place wins
    @(negedge clk);
    place = 1'b1; ship_row = 3'd1; ship_col = 3'd1; ship_vert = 1'b1;
    bus.shot_valid = 1'b1; bus.shot_row = 3'd2; bus.shot_col = 3'd4;
    #1 chk("collide_ready", bus.shot_ready, 0);
    @(negedge clk);
    place = 1'b0; bus.shot_valid = 1'b0;
    chk("collide_seg", seg_hit, 0);
`ifdef SHIP_HIT_TRACKER_SHOT_COUNT_EN
    chk("collide_count", shot_count, 0);
`endif
    repeat (3) @(negedge clk);
    chk("collide_no_result", bus.res_valid, 0);
    do_shot(2, 1, 1, 0, 3'b010);
    // reset during CHECK
    @(negedge clk);
    bus.shot_valid = 1'b1; bus.shot_row = 3'd1; bus.shot_col = 3'd1;
    @(negedge clk);
    bus.shot_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rchk_valid", bus.res_valid, 0);
    chk("rchk_seg", seg_hit, 0);
    chk("rchk_idle", bus.shot_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rchk_no_result", bus.res_valid, 0);
    do_shot(0, 1, 1, 0, 3'b010);
    // reset during RESP drops the pending result immediately
    @(negedge clk);
    bus.shot_valid = 1'b1; bus.shot_row = 3'd0; bus.shot_col = 3'd0;
    @(negedge clk);
    bus.shot_valid = 1'b0;
    @(negedge clk);
    chk("rresp_pre", bus.res_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("rresp_valid", bus.res_valid, 0);
    chk("rresp_seg", seg_hit, 0);
    chk("rresp_hit", bus.res_hit, 0);
    @(negedge clk);
    reset_n = 1'b1;
`ifdef SHIP_HIT_TRACKER_SHOT_COUNT_EN
    do_place(0, 0, 0);
    chk("count_place", shot_count, 0);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      bus.shot_valid = 1'b1; bus.shot_row = 3'd7; bus.shot_col = 3'd7; bus.res_ready = 1'b1;
      @(negedge clk);
      bus.shot_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      bus.res_ready = 1'b0;
      if (i == 9) chk("count_10", shot_count, 10);
    end
    chk("count_sat", shot_count, 255);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end
endmodule
